// File: rtl/aes_key_expand_seq.sv
// Iterative AES-128 key schedule: latches the cipher key on start, then streams
// round keys 0..NUM_ROUNDS over a valid/ready handshake, computing each in place.
module aes_key_expand_seq #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] LastIdx = 4'(NUM_ROUNDS);

    // FIPS-197 S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SboxTbl = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [0:0] {StIdle, StEmit} state_e;

    state_e       state_q;
    logic [127:0] round_key_q;
    logic [3:0]   round_idx_q;
    logic         key_valid_q;
    logic         busy_q;
    logic         done_q;
    logic [127:0] round_key_d;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        int unsigned pos;
        pos = 2047 - 8 * int'(b);
        return SboxTbl[pos -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        unique case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = round_key_q[127:96];
        w1 = round_key_q[95:64];
        w2 = round_key_q[63:32];
        w3 = round_key_q[31:0];
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(round_idx_q), 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        round_key_d = {n0, n1, n2, n3};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            round_key_q <= '0;
            round_idx_q <= '0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        round_key_q <= key_in;
                        round_idx_q <= '0;
                        key_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= StEmit;
                    end
                end
                StEmit: begin
                    if (key_ready) begin
                        if (round_idx_q == LastIdx) begin
                            // Last key handed off; key/index stay as the final round.
                            key_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= StIdle;
                        end else begin
                            round_key_q <= round_key_d;
                            round_idx_q <= round_idx_q + 4'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign round_key = round_key_q;
    assign round_idx = round_idx_q;
    assign key_valid = key_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Directed bench for aes_key_expand_seq using FIPS-197 and all-zero key vectors.
module tb_aes_key_expand_seq;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_idx;
    logic         key_valid;
    logic         busy;
    logic         done;

    int n_checks;
    int n_pass;

    logic [127:0] fips_key;
    logic [127:0] fips_exp [11];
    logic [127:0] zero_idx1;
    logic [127:0] zero_idx10;

    aes_key_expand_seq #(.NUM_ROUNDS(10)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .key_ready(key_ready),
        .round_key(round_key),
        .round_idx(round_idx),
        .key_valid(key_valid),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge with the DUT idle; returns at the negedge where key 0 is visible.
    task automatic pulse_start(input logic [127:0] k);
        start  = 1'b1;
        key_in = k;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        key_in = '0;
        key_ready = 1'b0;
        #2;
        n_checks++;
        if ({round_key, round_idx, key_valid, busy, done} !== 135'h0)
            $display("FAIL reset_outputs: got key=%h idx=%0d v=%b b=%b d=%b want all 0",
                     round_key, round_idx, key_valid, busy, done);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({key_valid, busy, done} !== 3'b000)
            $display("FAIL reset_idle: got v=%b b=%b d=%b want 000", key_valid, busy, done);
        else n_pass++;
    endtask

    task automatic test_fips_stream();
        key_ready = 1'b1;
        pulse_start(fips_key);
        for (int i = 0; i <= 10; i++) begin
            n_checks++;
            if (round_key !== fips_exp[i] || round_idx !== 4'(i) || key_valid !== 1'b1
                || busy !== 1'b1)
                $display("FAIL fips_idx%0d: got key=%h idx=%0d v=%b b=%b want key=%h idx=%0d v=1 b=1",
                         i, round_key, round_idx, key_valid, busy, fips_exp[i], i);
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || key_valid !== 1'b0 || round_idx !== 4'd10
            || round_key !== fips_exp[10])
            $display("FAIL fips_done: got d=%b b=%b v=%b idx=%0d key=%h want d=1 b=0 v=0 idx=10",
                     done, busy, key_valid, round_idx, round_key);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0)
            $display("FAIL fips_done_pulse: got done=%b want 0", done);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        key_ready = 1'b1;
        pulse_start(fips_key);
        for (int i = 0; i < 3; i++) @(negedge clk);
        n_checks++;
        if (round_idx !== 4'd3 || round_key !== fips_exp[3])
            $display("FAIL bp_reach_idx3: got idx=%0d key=%h want idx=3 key=%h",
                     round_idx, round_key, fips_exp[3]);
        else n_pass++;
        key_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (round_idx !== 4'd3 || round_key !== fips_exp[3] || key_valid !== 1'b1)
                $display("FAIL bp_hold%0d: got idx=%0d key=%h v=%b want idx=3 key=%h v=1",
                         i, round_idx, round_key, key_valid, fips_exp[3]);
            else n_pass++;
        end
        key_ready = 1'b1;
        @(negedge clk);
        for (int i = 4; i <= 10; i++) begin
            n_checks++;
            if (round_key !== fips_exp[i] || round_idx !== 4'(i))
                $display("FAIL bp_idx%0d: got key=%h idx=%0d want key=%h idx=%0d",
                         i, round_key, round_idx, fips_exp[i], i);
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1)
            $display("FAIL bp_done: got done=%b want 1", done);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_zero_key();
        key_ready = 1'b1;
        pulse_start('0);
        for (int i = 0; i <= 10; i++) begin
            if (i == 0 || i == 1 || i == 10) begin
                logic [127:0] want;
                want = (i == 0) ? 128'h0 : (i == 1) ? zero_idx1 : zero_idx10;
                n_checks++;
                if (round_key !== want || round_idx !== 4'(i))
                    $display("FAIL zero_idx%0d: got key=%h idx=%0d want key=%h",
                             i, round_key, round_idx, want);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_checks++;
        if (done !== 1'b1)
            $display("FAIL zero_done: got done=%b want 1", done);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        key_ready = 1'b1;
        pulse_start(fips_key);
        for (int i = 0; i <= 10; i++) begin
            if (i == 5) begin
                start  = 1'b1;
                key_in = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                start = 1'b0;
            end
            if (i >= 5) begin
                n_checks++;
                if (round_key !== fips_exp[i] || round_idx !== 4'(i))
                    $display("FAIL ign_idx%0d: got key=%h idx=%0d want key=%h idx=%0d",
                             i, round_key, round_idx, fips_exp[i], i);
                else n_pass++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0)
            $display("FAIL ign_done: got d=%b b=%b want d=1 b=0", done, busy);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        int saw_done;
        key_ready = 1'b1;
        pulse_start(fips_key);
        for (int i = 0; i < 5; i++) @(negedge clk);
        n_checks++;
        if (round_idx !== 4'd5)
            $display("FAIL ar_reach_idx5: got idx=%0d want 5", round_idx);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({round_key, round_idx, key_valid, busy, done} !== 135'h0)
            $display("FAIL ar_immediate: got key=%h idx=%0d v=%b b=%b d=%b want all 0",
                     round_key, round_idx, key_valid, busy, done);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1 || key_valid === 1'b1) saw_done++;
        end
        n_checks++;
        if (saw_done != 0)
            $display("FAIL ar_no_done: got %0d cycles with done/valid want 0", saw_done);
        else n_pass++;
        pulse_start(fips_key);
        n_checks++;
        if (round_key !== fips_key || round_idx !== 4'd0 || key_valid !== 1'b1)
            $display("FAIL ar_restart: got key=%h idx=%0d v=%b want key=%h idx=0 v=1",
                     round_key, round_idx, key_valid, fips_key);
        else n_pass++;
        for (int i = 0; i <= 10; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_start_in_done();
        int budget;
        key_ready = 1'b1;
        pulse_start(fips_key);
        budget = 0;
        while (done !== 1'b1 && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        n_checks++;
        if (done !== 1'b1)
            $display("FAIL sid_wait_done: got done=%b after %0d cycles want 1", done, budget);
        else n_pass++;
        pulse_start('0);
        n_checks++;
        if (round_key !== 128'h0 || round_idx !== 4'd0 || key_valid !== 1'b1)
            $display("FAIL sid_idx0: got key=%h idx=%0d v=%b want key=0 idx=0 v=1",
                     round_key, round_idx, key_valid);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (round_key !== zero_idx1 || round_idx !== 4'd1)
            $display("FAIL sid_idx1: got key=%h idx=%0d want key=%h idx=1",
                     round_key, round_idx, zero_idx1);
        else n_pass++;
        for (int i = 2; i <= 10; i++) @(negedge clk);
        n_checks++;
        if (round_key !== zero_idx10 || round_idx !== 4'd10)
            $display("FAIL sid_idx10: got key=%h idx=%0d want key=%h idx=10",
                     round_key, round_idx, zero_idx10);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1)
            $display("FAIL sid_done: got done=%b want 1", done);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        fips_key    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_exp[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_exp[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_exp[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_exp[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_exp[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_exp[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_exp[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_exp[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_exp[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_exp[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_exp[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        zero_idx1  = 128'h62636363626363636263636362636363;
        zero_idx10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

        test_reset();
        test_fips_stream();
        test_backpressure();
        test_zero_key();
        test_start_ignored();
        test_async_reset();
        test_start_in_done();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
